grid_line_scanner: RTL

- Generalised, parametrised sequencer that streams a character-grid BRAM line by line, over one or more passes, to a line-oriented consumer such as the assembler.
- Issues one read per cycle and tolerates any fixed BRAM read latency.
- Pulses new_line_out before each line and tags every character with its column, line and pass.
- Supports early line termination and abort from the consumer.

---
 rtl/grid_line_scanner_pkg.sv | 20 ++
 rtl/grid_line_scanner_scan_read_pipe.sv | 41 ++++
 rtl/grid_line_scanner.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/grid_line_scanner_pkg.sv
// grid_line_scanner_pkg: scanner state encoding, null-character constant and width helper.
package grid_line_scanner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NEW_LINE,
        SEND,
        DRAIN,
        DONE,
        ABORTED
    } scanner_state_t;

    localparam int SCANNER_NULL_CHAR = 0;

    // Width of an index into v entries, never narrower than one bit.
    function automatic int safe_clog2(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/grid_line_scanner_scan_read_pipe.sv
// scan_read_pipe: READ_LATENCY-deep {valid, column} delay line with synchronous kill.
module scan_read_pipe #(
    parameter int LATENCY = 2,
    parameter int XW      = 6
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          kill,
    input  logic          issue,
    input  logic [XW-1:0] x,
    output logic          valid,
    output logic [XW-1:0] col,
    output logic          empty
);

    logic [LATENCY-1:0] v;
    logic [XW-1:0]      xs [LATENCY];

    always_ff @(posedge clk_in) begin
        if (rst_in || kill) begin
            v <= '0;
        end else begin
            v[0] <= issue;
            for (int i = 1; i < LATENCY; i++) v[i] <= v[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < LATENCY; i++) xs[i] <= '0;
        end else begin
            xs[0] <= x;
            for (int i = 1; i < LATENCY; i++) xs[i] <= xs[i-1];
        end
    end

    assign valid = v[LATENCY-1];
    assign col   = xs[LATENCY-1];
    assign empty = ~|v;

endmodule

// File: rtl/grid_line_scanner.sv
// grid_line_scanner: streams a character-grid BRAM line by line over several passes.
// GRID_SCANNER_NULL_TERM_EN: a returned zero character ends the line instead of being presented.
module grid_line_scanner
    import grid_line_scanner_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 64,
    parameter int SCREEN_HEIGHT = 256,
    parameter int NUM_PASSES    = 2,
    parameter int READ_LATENCY  = 2,
    parameter int CHAR_WIDTH    = 8
) (
    input  logic                                              clk_in,
    input  logic                                              rst_in,
    input  logic                                              start_in,
    input  logic                                              abort_in,
    input  logic                                              line_done_in,
    output logic                                              rd_en_out,
    output logic [safe_clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] rd_addr_out,
    input  logic [CHAR_WIDTH-1:0]                             rd_data_in,
    output logic                                              new_line_out,
    output logic                                              char_valid_out,
    output logic [CHAR_WIDTH-1:0]                             char_out,
    output logic [safe_clog2(SCREEN_WIDTH)-1:0]               char_x_out,
    output logic [safe_clog2(SCREEN_HEIGHT)-1:0]              line_y_out,
    output logic [safe_clog2(NUM_PASSES+1)-1:0]               pass_out,
    output logic                                              busy_out,
    output logic                                              done_out,
    output logic                                              aborted_out
);

    localparam int AW = safe_clog2(SCREEN_WIDTH*SCREEN_HEIGHT);
    localparam int XW = safe_clog2(SCREEN_WIDTH);
    localparam int YW = safe_clog2(SCREEN_HEIGHT);
    localparam int PW = safe_clog2(NUM_PASSES+1);

    scanner_state_t state, state_n;
    logic [XW-1:0]  x, x_n, pipe_x;
    logic [YW-1:0]  y, y_n;
    logic [PW-1:0]  p, p_n;
    logic           kill, issue, pipe_valid, pipe_empty, null_hit, end_line, busy;
    logic           last_col, last_line, last_pass;

`ifdef GRID_SCANNER_NULL_TERM_EN
    assign null_hit = pipe_valid && (rd_data_in == CHAR_WIDTH'(SCANNER_NULL_CHAR));
`else
    assign null_hit = 1'b0;
`endif

    assign busy      = (state == NEW_LINE) || (state == SEND) || (state == DRAIN);
    assign end_line  = line_done_in || null_hit;
    assign last_col  = x == XW'(SCREEN_WIDTH-1);
    assign last_line = y == YW'(SCREEN_HEIGHT-1);
    assign last_pass = p == PW'(NUM_PASSES-1);

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        p_n     = p;
        kill    = 1'b0;
        issue   = 1'b0;
        if (start_in) begin
            state_n = NEW_LINE;
            x_n     = '0;
            y_n     = '0;
            p_n     = '0;
            kill    = 1'b1;
        end else if (abort_in && busy) begin
            state_n = ABORTED;
            kill    = 1'b1;
        end else begin
            case (state)
                NEW_LINE: begin
                    state_n = SEND;
                    x_n     = '0;
                end
                SEND: begin
                    if (end_line) begin
                        kill    = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        issue   = 1'b1;
                        x_n     = last_col ? '0 : x + 1'b1;
                        state_n = last_col ? DRAIN : SEND;
                    end
                end
                // An early end kills the pipe, so the empty test passes on the following cycle.
                DRAIN: begin
                    if (end_line) begin
                        kill = 1'b1;
                    end else if (pipe_empty) begin
                        if (!last_line) begin
                            y_n     = y + 1'b1;
                            state_n = NEW_LINE;
                        end else if (!last_pass) begin
                            p_n     = p + 1'b1;
                            y_n     = '0;
                            state_n = NEW_LINE;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            p     <= '0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            p     <= p_n;
        end
    end

    scan_read_pipe #(
        .LATENCY(READ_LATENCY),
        .XW     (XW)
    ) u_pipe (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .kill  (kill),
        .issue (issue),
        .x     (x),
        .valid (pipe_valid),
        .col   (pipe_x),
        .empty (pipe_empty)
    );

    assign rd_en_out      = issue;
    assign rd_addr_out    = issue ? AW'(y) * AW'(SCREEN_WIDTH) + AW'(x) : '0;
    assign new_line_out   = state == NEW_LINE;
    assign char_valid_out = pipe_valid && !null_hit;
    assign char_out       = char_valid_out ? rd_data_in : '0;
    assign char_x_out     = pipe_x;
    assign line_y_out     = y;
    assign pass_out       = p;
    assign busy_out       = busy;
    assign done_out       = state == DONE;
    assign aborted_out    = state == ABORTED;

endmodule
